snake_game_sequencer: RTL

- Top-level controller for the Snake datapath.
- Owns the game state machine (q_I, q_Run, q_Win, q_Lose) and generates the SCEN step pulse that advances the length/apple datapath.
- Latches player direction, rejecting 180-degree reversals, and drives In_Dirn.
- Detects wall/self collision and win length, ending the game before the offending step is issued.

---
 rtl/snake_pkg.sv | 38 +++
 rtl/snake_step_timer.sv | 39 +++
 rtl/snake_game_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared Snake definitions: direction and state encodings, grid size and
// cell-index/opposite-direction helpers used by the controller and datapath.
package snake_pkg;

  localparam int GRID_DIM = 16;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_I    = 2'd0,
    ST_RUN  = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_e;

  // Occupancy map index for a cell: X*16+Y.
  function automatic logic [7:0] cell_index(input logic [3:0] x, input logic [3:0] y);
    return {x, y};
  endfunction

  // Direction that would turn the snake back onto its own neck.
  function automatic dir_e opposite_dir(input dir_e d);
    dir_e r;
    unique case (d)
      DIR_UP:    r = DIR_DOWN;
      DIR_DOWN:  r = DIR_UP;
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_RIGHT: r = DIR_LEFT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Game-step divider: counts 0..STEP_DIV-1 while enabled, wraps, and flags
// the terminal count. Clear has priority and holds the count at zero.
module snake_step_timer #(
  parameter int STEP_DIV = 25000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise advance and wrap at the last value.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = en && (count_q == LAST);

endmodule

// File: rtl/snake_game_sequencer.sv
// Snake game controller: state machine, step pulse generation, direction
// latching with reversal rejection, and wall/self collision and win checks.
// Optional macro WRAP_WALLS_EN makes the grid toroidal (no wall collisions).
module snake_game_sequencer
  import snake_pkg::*;
#(
  parameter int         STEP_DIV  = 25000000,
  parameter int         WIN_LEN   = 32,
  parameter logic [1:0] INIT_DIRN = 2'b00
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Ack,
  input  logic         Btn_Up,
  input  logic         Btn_Down,
  input  logic         Btn_Left,
  input  logic         Btn_Right,
  input  logic [3:0]   Head_X,
  input  logic [3:0]   Head_Y,
  input  logic [7:0]   Length,
  input  logic [255:0] Cell_Snake,
  output logic         q_I,
  output logic         q_Run,
  output logic         q_Win,
  output logic         q_Lose,
  output logic         SCEN,
  output logic [1:0]   In_Dirn
);

  localparam logic [7:0] WIN_LEN_B = 8'(WIN_LEN);
  localparam dir_e       INIT_DIR  = dir_e'(INIT_DIRN);

  state_e     state_q, state_d;
  logic       scen_q, scen_d;
  dir_e       dirn_q, dirn_d;
  dir_e       pend_q, pend_d;
  logic       step_tc;
  dir_e       sel_dir;
  logic       sel_valid;
  logic [3:0] next_x, next_y;
  logic       wall_hit, self_hit, win_hit;

  snake_step_timer #(
    .STEP_DIV(STEP_DIV)
  ) u_step_timer (
    .Clk  (Clk),
    .Reset(Reset),
    .en   (state_q == ST_RUN),
    .clr  (state_q != ST_RUN),
    .tc   (step_tc)
  );

  // Pick a single button by priority Up > Down > Left > Right.
  always_comb begin
    sel_dir   = DIR_UP;
    sel_valid = 1'b1;
    if (Btn_Up) begin
      sel_dir = DIR_UP;
    end else if (Btn_Down) begin
      sel_dir = DIR_DOWN;
    end else if (Btn_Left) begin
      sel_dir = DIR_LEFT;
    end else if (Btn_Right) begin
      sel_dir = DIR_RIGHT;
    end else begin
      sel_valid = 1'b0;
    end
  end

  // Cell the head would enter on the next step; 4-bit math wraps mod 16.
  always_comb begin
    next_x = Head_X;
    next_y = Head_Y;
    unique case (dirn_q)
      DIR_UP:    next_y = Head_Y + 4'd1;
      DIR_DOWN:  next_y = Head_Y - 4'd1;
      DIR_LEFT:  next_x = Head_X - 4'd1;
      DIR_RIGHT: next_x = Head_X + 4'd1;
    endcase
  end

`ifdef WRAP_WALLS_EN
  assign wall_hit = 1'b0;
`else
  localparam logic [3:0] GRID_MAX = 4'(GRID_DIM - 1);

  // Leaving the grid edge in the committed direction is a wall collision.
  always_comb begin
    wall_hit = 1'b0;
    unique case (dirn_q)
      DIR_UP:    wall_hit = (Head_Y == GRID_MAX);
      DIR_DOWN:  wall_hit = (Head_Y == 4'd0);
      DIR_LEFT:  wall_hit = (Head_X == 4'd0);
      DIR_RIGHT: wall_hit = (Head_X == GRID_MAX);
    endcase
  end
`endif

  assign self_hit = Cell_Snake[cell_index(next_x, next_y)];
  assign win_hit  = (Length >= WIN_LEN_B);

  // Next state, step pulse and direction bookkeeping.
  always_comb begin
    state_d = state_q;
    scen_d  = 1'b0;
    dirn_d  = dirn_q;
    pend_d  = pend_q;
    unique case (state_q)
      ST_I: begin
        if (Start) begin
          state_d = ST_RUN;
          dirn_d  = INIT_DIR;
          pend_d  = INIT_DIR;
        end
      end
      ST_RUN: begin
        if (sel_valid && (sel_dir != opposite_dir(dirn_q))) begin
          pend_d = sel_dir;
        end
        if (win_hit) begin
          state_d = ST_WIN;
        end else if (step_tc) begin
          if (wall_hit || self_hit) begin
            state_d = ST_LOSE;
          end else begin
            scen_d = 1'b1;
            dirn_d = pend_d;
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (Ack) begin
          state_d = ST_I;
        end
      end
    endcase
  end

  // State, step pulse and direction registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_I;
      scen_q  <= 1'b0;
      dirn_q  <= INIT_DIR;
      pend_q  <= INIT_DIR;
    end else begin
      state_q <= state_d;
      scen_q  <= scen_d;
      dirn_q  <= dirn_d;
      pend_q  <= pend_d;
    end
  end

  assign q_I     = (state_q == ST_I);
  assign q_Run   = (state_q == ST_RUN);
  assign q_Win   = (state_q == ST_WIN);
  assign q_Lose  = (state_q == ST_LOSE);
  assign SCEN    = scen_q;
  assign In_Dirn = dirn_q;

endmodule
